// File: rtl/bubble_sort_p_pkg.sv
// Shared types and the element ordering rule for the in-place RAM sorters.
// Widths up to MAX_W bits are supported by the compare helper.
package sort_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CMP,
        WR_LO,
        WR_HI,
        ADV,
        DONE
    } sort_state_t;

    // Operands arrive zero-extended; shifting them up to the MSB makes one
    // signed or unsigned compare correct for any element width data_w.
    function automatic logic out_of_order(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      data_w,
        input logic             descending,
        input logic             signed_mode
    );
        logic [MAX_W-1:0] a_al;
        logic [MAX_W-1:0] b_al;
        logic             lt;
        logic             gt;
        a_al = a << (MAX_W - data_w);
        b_al = b << (MAX_W - data_w);
        if (signed_mode) begin
            lt = ($signed(a_al) < $signed(b_al));
            gt = ($signed(a_al) > $signed(b_al));
        end else begin
            lt = (a_al < b_al);
            gt = (a_al > b_al);
        end
        return descending ? lt : gt;
    endfunction

endpackage

// File: rtl/bubble_sort_p_if.sv
// Host handshake plus single-port RAM bus of the bubble sorter.
// The slave modport is the sorter; master is the host/RAM side.
interface bubble_sort_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) ();
    logic              start;
    logic [ADDR_W:0]   length;
    logic              descending;
    logic              signed_mode;
    logic              ready;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W:0]   pass_count;
    logic [CNT_W-1:0]  swap_count;

    modport slave (
        input  start, length, descending, signed_mode, rdata,
        output ready, done, addr, wren, wdata, pass_count, swap_count
    );

    modport master (
        output start, length, descending, signed_mode, rdata,
        input  ready, done, addr, wren, wdata, pass_count, swap_count
    );
endinterface

// File: rtl/bubble_sort_p_cmp.sv
// Combinational out-of-order test between two adjacent elements,
// shared by the sorter family.
module sort_cmp
    import sort_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              descending,
    input  logic              signed_mode,
    output logic              ooo
);
    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;

    assign a_ext = MAX_W'(a);
    assign b_ext = MAX_W'(b);
    assign ooo   = out_of_order(a_ext, b_ext, DATA_W, descending, signed_mode);
endmodule

// File: rtl/bubble_sort_p.sv
// In-place bubble sorter for an external single-port synchronous RAM with
// shrinking pass bound and early exit on a swap-free pass.
module bubble_sort_p
    import sort_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst_n,
    bubble_sort_p_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO_L   = (ADDR_W+1)'(2);

    sort_state_t       state;
    sort_state_t       state_next;
    logic [ADDR_W:0]   j;
    logic [ADDR_W:0]   j_inc;
    logic [ADDR_W:0]   bound;
    logic [ADDR_W:0]   last_sw;
    logic [ADDR_W:0]   len_clamped;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              swapped;
    logic              desc_q;
    logic              sgn_q;
    logic              from_rd_a;
    logic [ADDR_W:0]   pass_q;
    logic [CNT_W-1:0]  swap_q;
    logic              ooo;
    logic              pass_end;
    logic              stop;

    assign len_clamped = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
    assign j_inc       = j + ONE_L;
    assign pass_end    = !(j_inc < bound);
    assign stop        = !swapped || (last_sw == '0);

    sort_cmp #(.DATA_W(DATA_W)) u_cmp (
        .a           (a_q),
        .b           (bus.rdata),
        .descending  (desc_q),
        .signed_mode (sgn_q),
        .ooo         (ooo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (len_clamped >= TWO_L) ? RD_A : DONE;
            RD_A:    state_next = RD_B;
            RD_B:    state_next = CMP;
            CMP:     state_next = ooo ? WR_LO : ADV;
            WR_LO:   state_next = WR_HI;
            WR_HI:   state_next = ADV;
            ADV: begin
                if (!pass_end)  state_next = RD_B;
                else if (stop)  state_next = DONE;
                else            state_next = RD_A;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == IDLE);
        bus.done  = (state == DONE);
        bus.addr  = '0;
        bus.wren  = 1'b0;
        bus.wdata = '0;
        case (state)
            RD_A:  bus.addr = j[ADDR_W-1:0];
            RD_B:  bus.addr = j_inc[ADDR_W-1:0];
            WR_LO: begin
                bus.addr  = j[ADDR_W-1:0];
                bus.wren  = 1'b1;
                bus.wdata = b_q;
            end
            WR_HI: begin
                bus.addr  = j_inc[ADDR_W-1:0];
                bus.wren  = 1'b1;
                bus.wdata = a_q;
            end
            default: ;
        endcase
    end

    // A holds the element being carried upward; it is reloaded from RAM only
    // at the start of a pass, otherwise it follows the larger/smaller value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j         <= '0;
            bound     <= '0;
            last_sw   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped   <= 1'b0;
            desc_q    <= 1'b0;
            sgn_q     <= 1'b0;
            from_rd_a <= 1'b0;
            pass_q    <= '0;
            swap_q    <= '0;
        end else begin
            from_rd_a <= (state == RD_A);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pass_q <= '0;
                        swap_q <= '0;
                        if (len_clamped >= TWO_L) begin
                            desc_q  <= bus.descending;
                            sgn_q   <= bus.signed_mode;
                            bound   <= len_clamped - ONE_L;
                            j       <= '0;
                            swapped <= 1'b0;
                        end
                    end
                end
                RD_B: begin
                    if (from_rd_a) a_q <= bus.rdata;
                end
                CMP: begin
                    b_q <= bus.rdata;
                    if (!ooo) a_q <= bus.rdata;
                end
                WR_HI: begin
                    swapped <= 1'b1;
                    last_sw <= j;
                    if (swap_q != '1) swap_q <= swap_q + CNT_W'(1);
                end
                ADV: begin
                    if (!pass_end) begin
                        j <= j_inc;
                    end else begin
                        pass_q <= pass_q + ONE_L;
                        if (!stop) begin
                            bound   <= last_sw;
                            j       <= '0;
                            swapped <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pass_count = pass_q;
    assign bus.swap_count = swap_q;
endmodule

// File: tb/tb_bubble_sort_p.sv
// Self-checking bench for bubble_sort_p: directed cases plus randomized arrays
// compared against an array-level bubble sort model with cycle accounting.
module tb_bubble_sort_p;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 256;
    localparam int LIMIT  = 20000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bubble_sort_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    bubble_sort_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem      [DEPTH];
    logic [7:0] init_arr [DEPTH];
    logic [7:0] exp_arr  [DEPTH];
    logic       load_all;

    always @(posedge clk) begin
        if (load_all)      mem <= init_arr;
        else if (bus.wren) mem[bus.addr] <= bus.wdata;
        bus.rdata <= mem[bus.addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int elemVal(input logic [7:0] x, input bit sgn);
        return sgn ? int'($signed(x)) : int'(x);
    endfunction

    function automatic bit modelOoo(input logic [7:0] x, input logic [7:0] y, input bit desc, input bit sgn);
        return desc ? (elemVal(x, sgn) < elemVal(y, sgn)) : (elemVal(x, sgn) > elemVal(y, sgn));
    endfunction

    // Array-level bubble sort with the shrinking bound; cycles is the
    // start-to-done distance implied by the per-step costs.
    task automatic modelRun(input int n, input bit desc, input bit sgn,
                            output int passes, output int swaps, output int cycles);
        int bnd;
        int last;
        bit any;
        logic [7:0] t;
        passes = 0;
        swaps  = 0;
        if (n < 2) begin
            cycles = 1;
            return;
        end
        cycles = 0;
        bnd    = n - 1;
        do begin
            any  = 0;
            last = 0;
            cycles += 1;
            for (int k = 0; k < bnd; k++) begin
                cycles += 3;
                if (modelOoo(exp_arr[k], exp_arr[k+1], desc, sgn)) begin
                    t            = exp_arr[k];
                    exp_arr[k]   = exp_arr[k+1];
                    exp_arr[k+1] = t;
                    cycles += 2;
                    swaps++;
                    any  = 1;
                    last = k;
                end
            end
            passes++;
            bnd = last;
        end while (any && last != 0);
        cycles += 1;
    endtask

    task automatic loadRam();
        @(negedge clk) load_all = 1'b1;
        @(negedge clk) load_all = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input int length, input bit desc, input bit sgn,
                                 input int extra_start);
        int n;
        int e_pass;
        int e_swap;
        int e_cyc;
        int cycles;
        int wr_cnt;
        int bad;
        bit got;
        loadRam();
        n = (length > DEPTH) ? DEPTH : length;
        for (int i = 0; i < DEPTH; i++) exp_arr[i] = init_arr[i];
        modelRun(n, desc, sgn, e_pass, e_swap, e_cyc);
        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(bus.ready), 1);
        bus.length      = 9'(length);
        bus.descending  = desc;
        bus.signed_mode = sgn;
        bus.start       = 1'b1;
        cycles = 0;
        wr_cnt = 0;
        got    = 0;
        for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            cycles++;
            bus.start = (extra_start != 0 && cycles == extra_start);
            if (k == 0) begin
                bus.length      = 9'($urandom_range(0, 511));
                bus.descending  = 1'($urandom);
                bus.signed_mode = 1'($urandom);
            end
            if (bus.done) begin
                got = 1;
                break;
            end
            if (bus.wren) wr_cnt++;
        end
        bus.start = 1'b0;
        checkOutput({tag, "_done_seen"}, 32'(got), 1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(e_cyc));
        checkOutput({tag, "_pass_count"}, 32'(bus.pass_count), 32'(e_pass));
        checkOutput({tag, "_swap_count"}, 32'(bus.swap_count), 32'(e_swap));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(bus.done), 0);
        checkOutput({tag, "_ready_after"}, 32'(bus.ready), 1);
        checkOutput({tag, "_counts_hold"}, 32'(bus.swap_count), 32'(e_swap));
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_arr[i]) bad++;
        checkOutput({tag, "_ram_bad_entries"}, 32'(bad), 0);
        if (n < 2) checkOutput({tag, "_writes"}, 32'(wr_cnt), 0);
    endtask

    task automatic randomFill();
        for (int i = 0; i < DEPTH; i++) init_arr[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] t;
        int d;
        int p;
        rst_n           = 1'b0;
        load_all        = 1'b0;
        bus.start       = 1'b0;
        bus.length      = '0;
        bus.descending  = 1'b0;
        bus.signed_mode = 1'b0;
        randomFill();
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(bus.ready), 1);
        checkOutput("rst_done", 32'(bus.done), 0);
        checkOutput("rst_wren", 32'(bus.wren), 0);
        checkOutput("rst_addr", 32'(bus.addr), 0);
        checkOutput("rst_wdata", 32'(bus.wdata), 0);
        checkOutput("rst_pass", 32'(bus.pass_count), 0);
        checkOutput("rst_swap", 32'(bus.swap_count), 0);
        rst_n = 1'b1;

        randomFill();
        init_arr[0] = 8'd3; init_arr[1] = 8'd1; init_arr[2] = 8'd2;
        applyStimulus("t312", 3, 0, 0, 0);
        checkOutput("t312_m0", 32'(mem[0]), 1);
        checkOutput("t312_m1", 32'(mem[1]), 2);
        checkOutput("t312_m2", 32'(mem[2]), 3);
        checkOutput("t312_pass", 32'(bus.pass_count), 2);
        checkOutput("t312_swap", 32'(bus.swap_count), 2);

        init_arr[0] = 8'h80; init_arr[1] = 8'h01; init_arr[2] = 8'h7F;
        applyStimulus("sgn_asc", 3, 0, 1, 0);
        checkOutput("sgn_asc_m0", 32'(mem[0]), 32'h80);
        checkOutput("sgn_asc_m2", 32'(mem[2]), 32'h7F);
        checkOutput("sgn_asc_swap", 32'(bus.swap_count), 0);
        checkOutput("sgn_asc_pass", 32'(bus.pass_count), 1);

        applyStimulus("uns_desc", 3, 1, 0, 0);
        checkOutput("uns_desc_m0", 32'(mem[0]), 32'h80);
        checkOutput("uns_desc_m1", 32'(mem[1]), 32'h7F);
        checkOutput("uns_desc_m2", 32'(mem[2]), 32'h01);

        randomFill();
        applyStimulus("len0", 0, 0, 0, 0);
        applyStimulus("len1", 1, 1, 1, 0);

        for (int r = 0; r < 6; r++) begin
            randomFill();
            applyStimulus("rand", $urandom_range(2, 40), 1'($urandom), 1'($urandom), 0);
        end

        // Nearly sorted full-depth array keeps the pass count, and runtime, small.
        randomFill();
        for (int i = 1; i < DEPTH; i++) begin
            for (int k = i; k > 0 && init_arr[k-1] > init_arr[k]; k--) begin
                t = init_arr[k]; init_arr[k] = init_arr[k-1]; init_arr[k-1] = t;
            end
        end
        for (int s = 0; s < 30; s++) begin
            p = $urandom_range(0, DEPTH - 5);
            d = $urandom_range(1, 4);
            t = init_arr[p]; init_arr[p] = init_arr[p+d]; init_arr[p+d] = t;
        end
        applyStimulus("big", 300, 0, 0, 60);

        init_arr[0] = 8'd3; init_arr[1] = 8'd1; init_arr[2] = 8'd2;
        loadRam();
        @(negedge clk);
        bus.length      = 9'd3;
        bus.descending  = 1'b0;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        d = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.wren) begin
                d = 1;
                break;
            end
        end
        checkOutput("rstmid_wrlo_seen", 32'(d), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_ready", 32'(bus.ready), 1);
        checkOutput("rstmid_wren", 32'(bus.wren), 0);
        checkOutput("rstmid_swap", 32'(bus.swap_count), 0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) init_arr[i] = mem[i];
        applyStimulus("rstmid_fresh", 3, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
